biu_rr_arb: RTL
===============

# biu_rr_arb

Three-way round-robin bus arbiter and transaction sequencer for the picoJava bus interface. It shares the single pj bus between the instruction cache (icu), data cache (dcu) and stack manager (smu). It muxes the winning requester's address, type, size and write data onto the bus, tracks the single-ack or four-ack fill sequence, and routes returning acks to the owning requester. A watchdog counter terminates any transaction whose acks stall.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: idle-bus cycles tolerated inside a transaction before a synthesized error ack; legal range 2..255.

Ports:
- clk  in  1  bus clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- icu_req, dcu_req, smu_req  in  1 each  request, held until the final ack.
- icu_addr, dcu_addr, smu_addr  in  32 each  byte address.
- icu_type, dcu_type, smu_type  in  4 each  pj transaction type.
- icu_size, dcu_size, smu_size  in  2 each  transfer size.
- dcu_dataout, smu_dataout  in  32 each  write data.
- biu_icu_ack, biu_dcu_ack, biu_smu_ack  out  2 each  routed ack, as {error, normal}.
- pj_addr  out  30  winning address bits [29:0].
- pj_type  out  4  winning type.
- pj_size  out  2  winning size.
- pj_data_out  out  32  smu_dataout when smu owns the bus, otherwise dcu_dataout.
- pj_tv  out  1  transfer valid.
- pj_ale  out  1  address latch enable, active low.
- pj_ack  in  2  bus ack, as {error, normal}.
- bus_timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation
- Requester IDs: 0 = icu, 1 = dcu, 2 = smu.
- State machine, one-hot: IDLE, REQ_ACTIVE, FILL3, FILL2, FILL1.
- IDLE:
  - Winner is the first asserted request scanning last_grant+1, +2, +3 (mod 3).
  - Grant is combinational, so the bus muxes show the winner in the same cycle.
  - Any request present: pj_tv=1, owner register loads the winner, last_grant loads the winner, go to REQ_ACTIVE.
- Outside IDLE the muxes select owner, not the live winner.
- Ack decode uses the owner's type, captured into a type register when leaving IDLE:
  - single = type[1].
  - burst = type[3] | (type[2] & ~type[1]) | (type[3:1] == 0).
- REQ_ACTIVE:
  - error ack, or normal ack with single → IDLE.
  - normal ack with burst → FILL3.
  - otherwise hold.
- FILL3 and FILL2: error → IDLE; normal → FILL2 and FILL1 respectively; otherwise hold.
- FILL1: any ack → IDLE.
- Ack routing:
  - Outside IDLE, pj_ack is copied to the owner's biu_*_ack; the other two acks are 00.
  - In IDLE, all acks are 00 and pj_ack is ignored.
- Watchdog:
  - 8-bit counter, cleared in IDLE and on any nonzero pj_ack; otherwise increments.
  - When it reaches TIMEOUT_CYCLES: owner ack = 10, bus_timeout = 1, next state IDLE. Both happen in that cycle.
- pj_ack = 11 is treated as an error.
- last_grant updates only on a grant.

## Timing
- Reset values:
  - state IDLE, owner 0, last_grant 0, type register 0, counter 0.
  - With last_grant 0, the first scan order is dcu, smu, icu.
- Output values out of reset: all biu acks 00, bus_timeout 0. pj_tv/pj_ale/muxes follow the combinational rules with the reset state.
- pj_tv = (any_req & IDLE) | REQ_ACTIVE.
- pj_ale = ~(pj_tv & IDLE); it is low for exactly the address cycle.
- Single transfer: the earliest ack is in the cycle after the grant cycle.
- Back-to-back transfers:
  - After the final ack the FSM returns to IDLE.
  - A new grant occurs in that IDLE cycle, so there is a minimum of one IDLE cycle between transactions.
- Requests are not sampled outside IDLE. Dropping a request mid-transaction does not abort it.
- Reset asserted mid-burst: the next cycle is IDLE with no acks routed.

## Structure
- Package biu_pkg holds:
  - state one-hot constants.
  - requester ID constants.
  - type-decode functions for single and burst.
  - ack bit positions.
- One sub-module, biu_rr_pick: pure-combinational 3-way rotating priority picker. Inputs: req[2:0], last[1:0]. Outputs: gnt_valid, gnt_id[1:0].
- Counter, FSM and muxes live in the top level.

## Test plan
- Reset, then all three requests in the same cycle → grants in order dcu, smu, icu on successive transactions; pj_ale low only in each grant cycle.
- icu type 0000 (burst), four normal acks → biu_icu_ack = 01 four times; states REQ_ACTIVE, FILL3, FILL2, FILL1, IDLE; dcu/smu acks stay 00.
- dcu type 0010 (single) write, dcu_dataout = 0xDEADBEEF → pj_data_out = 0xDEADBEEF and pj_addr = dcu_addr[29:0] while active; one ack returns to IDLE.
- smu burst, error ack 10 in FILL2 → biu_smu_ack = 10 once, immediate IDLE.
- TIMEOUT_CYCLES = 4, icu single, no pj_ack → biu_icu_ack = 10 and bus_timeout = 1 in the 4th cycle after the grant, then IDLE; a pending dcu request is granted next.
- Reset asserted in FILL3 → IDLE next cycle, all acks 00, first scan order back to dcu, smu, icu.

Source files
------------

// File: rtl/biu_pkg.sv
// biu_pkg: shared constants and helpers for the picoJava bus interface arbiter.
//   - one-hot FSM state encodings
//   - requester IDs (icu/dcu/smu)
//   - bit positions inside a {error, normal} ack pair
//   - transaction-type decode functions for single and four-beat bursts
package biu_pkg;

    // One-hot arbiter states
    localparam logic [4:0] ST_IDLE       = 5'b00001;
    localparam logic [4:0] ST_REQ_ACTIVE = 5'b00010;
    localparam logic [4:0] ST_FILL3      = 5'b00100;
    localparam logic [4:0] ST_FILL2      = 5'b01000;
    localparam logic [4:0] ST_FILL1      = 5'b10000;

    // Requester IDs
    localparam logic [1:0] ID_ICU = 2'd0;
    localparam logic [1:0] ID_DCU = 2'd1;
    localparam logic [1:0] ID_SMU = 2'd2;

    // Ack pair bit positions: {error, normal}
    localparam int ACK_NORMAL = 0;
    localparam int ACK_ERROR  = 1;

    // A single-ack transaction completes on its first normal ack
    function automatic logic type_is_single(input logic [3:0] t);
        return t[1];
    endfunction

    // A burst transaction needs four normal acks (REQ_ACTIVE + three fills)
    function automatic logic type_is_burst(input logic [3:0] t);
        return t[3] | (t[2] & ~t[1]) | (t[3:1] == 3'b000);
    endfunction

endpackage

// File: rtl/biu_rr_pick.sv
// biu_rr_pick: combinational three-way rotating-priority picker.
//   req[2:0]      request vector indexed by requester ID
//   last[1:0]     ID granted most recently; scanning starts just after it
//   gnt_valid     any request present
//   gnt_id[1:0]   winning requester ID (ID_ICU when nothing is requested)
module biu_rr_pick
    import biu_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic       gnt_valid,
    output logic [1:0] gnt_id
);

    logic [1:0] first_s;
    logic [1:0] second_s;
    logic [1:0] third_s;

    // Scan order is last+1, last+2, last+3 (mod 3)
    always_comb begin
        first_s  = ID_DCU;
        second_s = ID_SMU;
        third_s  = ID_ICU;
        case (last)
            ID_ICU: begin
                first_s  = ID_DCU;
                second_s = ID_SMU;
                third_s  = ID_ICU;
            end
            ID_DCU: begin
                first_s  = ID_SMU;
                second_s = ID_ICU;
                third_s  = ID_DCU;
            end
            ID_SMU: begin
                first_s  = ID_ICU;
                second_s = ID_DCU;
                third_s  = ID_SMU;
            end
            default: begin
                first_s  = ID_DCU;
                second_s = ID_SMU;
                third_s  = ID_ICU;
            end
        endcase
    end

    // First asserted request in scan order wins
    always_comb begin
        gnt_valid = |req;
        gnt_id    = ID_ICU;
        if (req[first_s]) begin
            gnt_id = first_s;
        end else if (req[second_s]) begin
            gnt_id = second_s;
        end else if (req[third_s]) begin
            gnt_id = third_s;
        end else begin
            gnt_id = ID_ICU;
        end
    end

endmodule

// File: rtl/biu_rr_arb.sv
// biu_rr_arb: round-robin arbiter and transaction sequencer for the pj bus.
//   Requesters icu/dcu/smu present req/addr/type/size (dcu/smu also write
//   data). The winner is muxed onto pj_addr/pj_type/pj_size/pj_data_out with
//   pj_tv/pj_ale framing; pj_ack ({error, normal}) is routed back to the
//   owner as biu_*_ack. A watchdog synthesizes an error ack and pulses
//   bus_timeout when a transaction sees TIMEOUT_CYCLES cycles without acks.
module biu_rr_arb
    import biu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        icu_req,
    input  logic        dcu_req,
    input  logic        smu_req,
    input  logic [31:0] icu_addr,
    input  logic [31:0] dcu_addr,
    input  logic [31:0] smu_addr,
    input  logic [3:0]  icu_type,
    input  logic [3:0]  dcu_type,
    input  logic [3:0]  smu_type,
    input  logic [1:0]  icu_size,
    input  logic [1:0]  dcu_size,
    input  logic [1:0]  smu_size,
    input  logic [31:0] dcu_dataout,
    input  logic [31:0] smu_dataout,
    output logic [1:0]  biu_icu_ack,
    output logic [1:0]  biu_dcu_ack,
    output logic [1:0]  biu_smu_ack,
    output logic [29:0] pj_addr,
    output logic [3:0]  pj_type,
    output logic [1:0]  pj_size,
    output logic [31:0] pj_data_out,
    output logic        pj_tv,
    output logic        pj_ale,
    input  logic [1:0]  pj_ack,
    output logic        bus_timeout
);

    // Fire when the incremented count would reach TIMEOUT_CYCLES, so the
    // error ack lands in the TIMEOUT_CYCLES-th cycle after the grant.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [4:0] state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [3:0] type_q, type_d;
    logic [7:0] wdog_q, wdog_d;

    logic       gnt_valid_s;
    logic [1:0] gnt_id_s;
    logic [1:0] sel_s;
    logic       idle_s;
    logic       ack_err_s;
    logic       ack_norm_s;
    logic       ack_any_s;
    logic       timeout_s;
    logic [1:0] route_ack_s;
    logic       unused_s;

    biu_rr_pick u_pick (
        .req       ({smu_req, dcu_req, icu_req}),
        .last      (last_q),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    assign idle_s     = (state_q == ST_IDLE);
    assign ack_err_s  = pj_ack[ACK_ERROR];   // 11 counts as an error
    assign ack_norm_s = pj_ack[ACK_NORMAL] & ~pj_ack[ACK_ERROR];
    assign ack_any_s  = |pj_ack;
    assign timeout_s  = ~idle_s & ~ack_any_s & (wdog_q == WDOG_LAST);
    assign unused_s   = ^{icu_addr[31:30], dcu_addr[31:30], smu_addr[31:30]};

    assign pj_tv       = (gnt_valid_s & idle_s) | (state_q == ST_REQ_ACTIVE);
    assign pj_ale      = ~(pj_tv & idle_s);
    assign bus_timeout = timeout_s;

    // Bus mux select: live winner while arbitrating, latched owner afterwards
    always_comb begin
        if (idle_s) begin
            sel_s = gnt_id_s;
        end else begin
            sel_s = owner_q;
        end
    end

    // Request-field mux onto the pj bus
    always_comb begin
        pj_addr = icu_addr[29:0];
        pj_type = icu_type;
        pj_size = icu_size;
        case (sel_s)
            ID_DCU: begin
                pj_addr = dcu_addr[29:0];
                pj_type = dcu_type;
                pj_size = dcu_size;
            end
            ID_SMU: begin
                pj_addr = smu_addr[29:0];
                pj_type = smu_type;
                pj_size = smu_size;
            end
            default: begin
                pj_addr = icu_addr[29:0];
                pj_type = icu_type;
                pj_size = icu_size;
            end
        endcase
        if (sel_s == ID_SMU) begin
            pj_data_out = smu_dataout;
        end else begin
            pj_data_out = dcu_dataout;
        end
    end

    // Ack routing: only the owner sees acks, and only outside IDLE
    always_comb begin
        route_ack_s = 2'b00;
        if (idle_s) begin
            route_ack_s = 2'b00;
        end else if (timeout_s) begin
            route_ack_s = 2'b10;
        end else begin
            route_ack_s = pj_ack;
        end
        biu_icu_ack = (owner_q == ID_ICU) ? route_ack_s : 2'b00;
        biu_dcu_ack = (owner_q == ID_DCU) ? route_ack_s : 2'b00;
        biu_smu_ack = (owner_q == ID_SMU) ? route_ack_s : 2'b00;
    end

    // Next-state logic for FSM, ownership, type capture and watchdog
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        type_d  = type_q;
        if (timeout_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid_s) begin
                        state_d = ST_REQ_ACTIVE;
                        owner_d = gnt_id_s;
                        last_d  = gnt_id_s;
                        type_d  = pj_type;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ_ACTIVE: begin
                    if (ack_err_s) begin
                        state_d = ST_IDLE;
                    end else if (ack_norm_s && type_is_single(type_q)) begin
                        state_d = ST_IDLE;
                    end else if (ack_norm_s && type_is_burst(type_q)) begin
                        state_d = ST_FILL3;
                    end else begin
                        state_d = ST_REQ_ACTIVE;
                    end
                end
                ST_FILL3: begin
                    if (ack_err_s) begin
                        state_d = ST_IDLE;
                    end else if (ack_norm_s) begin
                        state_d = ST_FILL2;
                    end else begin
                        state_d = ST_FILL3;
                    end
                end
                ST_FILL2: begin
                    if (ack_err_s) begin
                        state_d = ST_IDLE;
                    end else if (ack_norm_s) begin
                        state_d = ST_FILL1;
                    end else begin
                        state_d = ST_FILL2;
                    end
                end
                ST_FILL1: begin
                    if (ack_any_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FILL1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (idle_s || ack_any_s || timeout_s) begin
            wdog_d = 8'd0;
        end else begin
            wdog_d = wdog_q + 8'd1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= ID_ICU;
            last_q  <= ID_ICU;
            type_q  <= 4'd0;
            wdog_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            type_q  <= type_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule
